// File: rtl/mips_cpu_div_unit.sv
// mips_cpu_div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Divides operand magnitudes over 32 iterations, then applies a sign-fix cycle.
// Quotient goes to LO, remainder to HI.
// Optional build macro MIPS_DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iterations
// and returns Q=all-ones, R=raw dividend with no sign fix.
module mips_cpu_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,      // asynchronous, active-low
   input  logic             i_start,
   input  logic             i_is_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

   state_t           r_state, w_state_next;
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_rem;      // partial remainder; always below the divisor
   logic [WIDTH-1:0] r_quo;      // dividend bits shift out as quotient bits shift in
   logic [WIDTH-1:0] r_dvs;
   logic             r_qneg, r_rneg;
   logic             r_busy, r_done;
   logic [WIDTH-1:0] r_q_out, r_r_out;

   logic             w_accept, w_div_zero, w_ge;
   logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
   logic [WIDTH:0]   w_shift, w_diff;

   // Start is ignored outside IDLE and in the cycle done is reported.
   assign w_accept  = i_start && (r_state == StIdle) && !r_done;
   assign w_dvd_mag = (i_is_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
   assign w_dvs_mag = (i_is_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

`ifdef MIPS_DIV_ZERO_SHORTCUT_EN
   assign w_div_zero = (i_divisor == '0);
`else
   assign w_div_zero = 1'b0;
`endif

   // 33-bit shifted remainder; the borrow bit of the trial subtraction decides the quotient bit.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign w_ge    = ~w_diff[WIDTH];

   // State register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (w_accept) w_state_next = w_div_zero ? StFix : StCalc;
         StCalc: if (r_cnt == CntW'(WIDTH - 1)) w_state_next = StFix;
         StFix:  w_state_next = StDone;
         StDone: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Datapath: operand capture, iteration, sign fix and registered status flags.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_q_out <= '0;
         r_r_out <= '0;
      end else begin
         r_busy <= (r_state == StCalc) || (r_state == StFix);
         r_done <= (r_state == StDone);
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_cnt <= '0;
                  if (w_div_zero) begin
                     // Preload the final values so FIX passes them through unchanged.
                     r_rem  <= i_dividend;
                     r_quo  <= '1;
                     r_dvs  <= '0;
                     r_qneg <= 1'b0;
                     r_rneg <= 1'b0;
                  end else begin
                     r_rem  <= '0;
                     r_quo  <= w_dvd_mag;
                     r_dvs  <= w_dvs_mag;
                     r_qneg <= i_is_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                     r_rneg <= i_is_signed && i_dividend[WIDTH-1];
                  end
               end
            end
            StCalc: begin
               r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt + CntW'(1);
            end
            StFix: begin
               r_q_out <= r_qneg ? -r_quo : r_quo;
               r_r_out <= r_rneg ? -r_rem : r_rem;
            end
            default: ;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_quotient  = r_q_out;
   assign o_remainder = r_r_out;

endmodule

// File: tb/tb_mips_cpu_div_unit.sv
// Self-checking bench for mips_cpu_div_unit: directed cases, start-during-CALC,
// reset mid-operation and randomized operands against an arithmetic reference model.
// Honours MIPS_DIV_ZERO_SHORTCUT_EN for zero-divisor latency and results.
module tb_mips_cpu_div_unit;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic        i_is_signed;
   logic [31:0] i_dividend;
   logic [31:0] i_divisor;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_quotient;
   logic [31:0] o_remainder;

   int n_checks = 0;
   int n_pass   = 0;

   mips_cpu_div_unit #(.WIDTH(32)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_is_signed (i_is_signed),
      .i_dividend  (i_dividend),
      .i_divisor   (i_divisor),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_quotient  (o_quotient),
      .o_remainder (o_remainder)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Reference: MIPS division semantics from plain arithmetic.
   function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      int sa, sb;
      logic [31:0] ma;
`ifdef MIPS_DIV_ZERO_SHORTCUT_EN
      if (b == 32'd0) begin
         q = 32'hFFFFFFFF;
         r = a;
         return;
      end
`endif
      if (!sgn) begin
         if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
         end else begin
            q = a / b;
            r = a % b;
         end
      end else if (b == 32'd0) begin
         ma = a[31] ? (32'd0 - a) : a;
         q  = a[31] ? (32'd0 - 32'hFFFFFFFF) : 32'hFFFFFFFF;
         r  = a[31] ? (32'd0 - ma) : ma;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         q = 32'h80000000;
         r = 32'd0;
      end else begin
         sa = a;
         sb = b;
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end
   endfunction

   function automatic int exp_latency(input logic [31:0] b);
`ifdef MIPS_DIV_ZERO_SHORTCUT_EN
      if (b == 32'd0) return 2;
`endif
      return 34;
   endfunction

   // One division: start accepted at edge N, done expected after edge N+latency.
   // inject re-asserts start with junk operands during CALC.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input bit inject);
      logic [31:0] eq, er;
      int lat, elat;
      model(sgn, a, b, eq, er);
      elat = exp_latency(b);
      lat  = 0;
      @(negedge i_clk);
      i_start     = 1'b1;
      i_is_signed = sgn;
      i_dividend  = a;
      i_divisor   = b;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start    = 1'b0;
      i_dividend = $urandom;
      i_divisor  = $urandom;
      for (int k = 1; k <= 60; k++) begin
         @(posedge i_clk);
         #1;
         if (k == 1) chk({tag, ".busy_early"}, 32'(o_busy), 32'd1);
         if (inject && k == 5) begin
            i_start     = 1'b1;
            i_is_signed = ~sgn;
            i_dividend  = $urandom;
            i_divisor   = $urandom_range(1, 9);
         end
         if (inject && k == 6) i_start = 1'b0;
         if (o_done) begin
            lat = k;
            break;
         end
      end
      chk({tag, ".latency"}, 32'(lat), 32'(elat));
      chk({tag, ".busy_at_done"}, 32'(o_busy), 32'd0);
      chk({tag, ".quotient"}, o_quotient, eq);
      chk({tag, ".remainder"}, o_remainder, er);
      @(posedge i_clk);
      #1;
      chk({tag, ".done_pulse"}, 32'(o_done), 32'd0);
      chk({tag, ".q_hold"}, o_quotient, eq);
      chk({tag, ".r_hold"}, o_remainder, er);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          done_seen;

      i_reset     = 1'b0;
      i_start     = 1'b0;
      i_is_signed = 1'b0;
      i_dividend  = '0;
      i_divisor   = '0;
      #12;
      chk("rst.busy", 32'(o_busy), 32'd0);
      chk("rst.done", 32'(o_done), 32'd0);
      chk("rst.q", o_quotient, 32'd0);
      chk("rst.r", o_remainder, 32'd0);
      @(negedge i_clk);
      i_reset = 1'b1;

      // Directed cases.
      do_div("divu_10_4", 1'b0, 32'h0000000A, 32'h00000004, 1'b0);
      do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      do_div("divu_f9_2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      do_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      do_div("div_min_3", 1'b1, 32'h80000000, 32'h00000003, 1'b0);
      do_div("divu_zero", 1'b0, 32'h12345678, 32'h00000000, 1'b0);
      do_div("div_neg_zero", 1'b1, 32'hFFFFFFF0, 32'h00000000, 1'b0);
      do_div("div_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 1'b0);

      // Start during CALC is ignored; follow-up start two cycles after done is accepted.
      do_div("inject", 1'b0, 32'h0BADF00D, 32'h00000123, 1'b1);
      do_div("after_inject", 1'b1, 32'hFFFF0000, 32'h00000010, 1'b0);

      // Reset during CALC aborts with no done pulse.
      @(negedge i_clk);
      i_start     = 1'b1;
      i_is_signed = 1'b0;
      i_dividend  = 32'd1000;
      i_divisor   = 32'd7;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (10) @(posedge i_clk);
      #2;
      i_reset = 1'b0;
      #1;
      chk("midrst.busy", 32'(o_busy), 32'd0);
      chk("midrst.done", 32'(o_done), 32'd0);
      chk("midrst.q", o_quotient, 32'd0);
      chk("midrst.r", o_remainder, 32'd0);
      done_seen = 0;
      repeat (3) begin
         @(posedge i_clk);
         #1;
         if (o_done) done_seen++;
      end
      @(negedge i_clk);
      i_reset = 1'b1;
      repeat (40) begin
         @(posedge i_clk);
         #1;
         if (o_done) done_seen++;
      end
      chk("midrst.no_done", 32'(done_seen), 32'd0);
      do_div("after_rst", 1'b0, 32'd1000, 32'd7, 1'b0);

      // Randomized operands.
      for (int i = 0; i < 16; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = 32'($urandom_range(1, 255));
            2: rb = 32'd0 - 32'($urandom_range(1, 16));
            default: rb = 32'd0;
         endcase
         do_div($sformatf("rnd%0d", i), rs, ra, rb, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the bench always terminates.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
